hazard_unit: RTL and testbench

- Pipeline hazard and flow controller; consumes the decoded control signals the ID-stage decoder produces, as they travel down ID/EX/MEM/WB.
- Generates IF/ID stall, ID/EX bubble, wrong-path flush and ALU operand forwarding selects.
- Sequences SYSCALL so it fires only with the back end drained.
- Keeps saturating stall/flush performance counters.

---
 rtl/hazard_unit.sv | 124 ++++++++++++
 tb/tb_hazard_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard/flow controller: load-use stall, redirect flush, SYSCALL drain
// sequencing, EX operand forwarding selects and saturating stall/flush counters.
module hazard_unit #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_b,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    input  logic             i_id_sys,
    input  logic [4:0]       i_ex_rs,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_ex_memRead,
    input  logic             i_ex_regWrite,
    input  logic [4:0]       i_ex_dest,
    input  logic             i_ex_redirect,
    input  logic             i_mem_regWrite,
    input  logic [4:0]       i_mem_dest,
    input  logic             i_wb_regWrite,
    input  logic [4:0]       i_wb_dest,
    output logic             o_stall_if_id,
    output logic             o_bubble_ex,
    output logic             o_flush_if_id,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_sys_fire,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, SYS_DRAIN, SYS_FIRE} state_t;

    state_t          r_state, w_next_state;
    logic [DW-1:0]   r_drain_cnt, w_next_cnt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic            w_load_use;
    logic            w_unused;

    // The EX write-enable is carried for completeness; only loads matter for stalls.
    assign w_unused = i_ex_regWrite;

    assign w_load_use = i_ex_memRead && (i_ex_dest != 5'd0) &&
                        ((i_id_uses_rs && (i_id_rs == i_ex_dest)) ||
                         (i_id_uses_rt && (i_id_rt == i_ex_dest)));

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic mem_we, input logic [4:0] mem_d,
                                           input logic wb_we,  input logic [4:0] wb_d);
        if (mem_we && (mem_d != 5'd0) && (mem_d == src))     return 2'b10;
        else if (wb_we && (wb_d != 5'd0) && (wb_d == src))   return 2'b01;
        else                                                 return 2'b00;
    endfunction

    assign o_fwd_a = fwd_sel(i_ex_rs, i_mem_regWrite, i_mem_dest, i_wb_regWrite, i_wb_dest);
    assign o_fwd_b = fwd_sel(i_ex_rt, i_mem_regWrite, i_mem_dest, i_wb_regWrite, i_wb_dest);

    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_drain_cnt;
        o_stall_if_id = 1'b0;
        o_bubble_ex   = 1'b0;
        o_flush_if_id = 1'b0;
        o_sys_fire    = 1'b0;
        // A redirect kills whatever sits in ID, including a pending SYSCALL.
        if (i_ex_redirect) begin
            o_flush_if_id = 1'b1;
            o_bubble_ex   = 1'b1;
            w_next_state  = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_id_sys) begin
                        o_stall_if_id = 1'b1;
                        o_bubble_ex   = 1'b1;
                        w_next_state  = SYS_DRAIN;
                        w_next_cnt    = DW'(DRAIN_CYCLES - 1);
                    end else if (w_load_use) begin
                        o_stall_if_id = 1'b1;
                        o_bubble_ex   = 1'b1;
                    end
                end
                SYS_DRAIN: begin
                    o_stall_if_id = 1'b1;
                    o_bubble_ex   = 1'b1;
                    if (r_drain_cnt == '0) w_next_state = SYS_FIRE;
                    else                   w_next_cnt   = r_drain_cnt - 1'b1;
                end
                SYS_FIRE: begin
                    o_sys_fire   = 1'b1;
                    o_bubble_ex  = 1'b1;
                    w_next_state = RUN;
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_stall_if_id && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (o_flush_if_id && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall_count = r_stall_cnt;
    assign o_flush_count = r_flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; driver pushes expected outputs, a negedge monitor checks.
module tb_hazard_unit;
    typedef struct packed {
        logic       rst_b;
        logic [4:0] id_rs, id_rt;
        logic       id_uses_rs, id_uses_rt, id_sys;
        logic [4:0] ex_rs, ex_rt;
        logic       ex_memRead, ex_regWrite;
        logic [4:0] ex_dest;
        logic       ex_redirect;
        logic       mem_regWrite;
        logic [4:0] mem_dest;
        logic       wb_regWrite;
        logic [4:0] wb_dest;
    } in_t;

    typedef struct {
        string       nm;
        logic        stall, bubble, flush, fire;
        logic [1:0]  fa, fb;
        logic [31:0] scnt, fcnt;
        logic [2:0]  sat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t v;
    logic        stall, bubble, flush, fire;
    logic [1:0]  fa, fb;
    logic [31:0] scnt, fcnt;
    logic        s_stall, s_bubble, s_flush, s_fire;
    logic [1:0]  s_fa, s_fb;
    logic [2:0]  s_scnt, s_fcnt;

    hazard_unit #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst_b(v.rst_b), .i_id_rs(v.id_rs), .i_id_rt(v.id_rt),
        .i_id_uses_rs(v.id_uses_rs), .i_id_uses_rt(v.id_uses_rt), .i_id_sys(v.id_sys),
        .i_ex_rs(v.ex_rs), .i_ex_rt(v.ex_rt), .i_ex_memRead(v.ex_memRead),
        .i_ex_regWrite(v.ex_regWrite), .i_ex_dest(v.ex_dest), .i_ex_redirect(v.ex_redirect),
        .i_mem_regWrite(v.mem_regWrite), .i_mem_dest(v.mem_dest),
        .i_wb_regWrite(v.wb_regWrite), .i_wb_dest(v.wb_dest),
        .o_stall_if_id(stall), .o_bubble_ex(bubble), .o_flush_if_id(flush),
        .o_fwd_a(fa), .o_fwd_b(fb), .o_sys_fire(fire),
        .o_stall_count(scnt), .o_flush_count(fcnt));

    // Narrow-counter copy on the same stimulus, used to observe saturation.
    hazard_unit #(.DRAIN_CYCLES(3), .CNT_W(3)) dut_sat (
        .i_clk(clk), .i_rst_b(v.rst_b), .i_id_rs(v.id_rs), .i_id_rt(v.id_rt),
        .i_id_uses_rs(v.id_uses_rs), .i_id_uses_rt(v.id_uses_rt), .i_id_sys(v.id_sys),
        .i_ex_rs(v.ex_rs), .i_ex_rt(v.ex_rt), .i_ex_memRead(v.ex_memRead),
        .i_ex_regWrite(v.ex_regWrite), .i_ex_dest(v.ex_dest), .i_ex_redirect(v.ex_redirect),
        .i_mem_regWrite(v.mem_regWrite), .i_mem_dest(v.mem_dest),
        .i_wb_regWrite(v.wb_regWrite), .i_wb_dest(v.wb_dest),
        .o_stall_if_id(s_stall), .o_bubble_ex(s_bubble), .o_flush_if_id(s_flush),
        .o_fwd_a(s_fa), .o_fwd_b(s_fb), .o_sys_fire(s_fire),
        .o_stall_count(s_scnt), .o_flush_count(s_fcnt));

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    logic [31:0] m_scnt = 0, m_fcnt = 0;
    logic [2:0]  m_sat = 0;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle with a pending entry is checked.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "stall",  {31'd0, stall},  {31'd0, e.stall});
                chk(e.nm, "bubble", {31'd0, bubble}, {31'd0, e.bubble});
                chk(e.nm, "flush",  {31'd0, flush},  {31'd0, e.flush});
                chk(e.nm, "fire",   {31'd0, fire},   {31'd0, e.fire});
                chk(e.nm, "fwd_a",  {30'd0, fa},     {30'd0, e.fa});
                chk(e.nm, "fwd_b",  {30'd0, fb},     {30'd0, e.fb});
                chk(e.nm, "stall_cnt", scnt, e.scnt);
                chk(e.nm, "flush_cnt", fcnt, e.fcnt);
                chk(e.nm, "sat_cnt", {29'd0, s_scnt}, {29'd0, e.sat});
            end
        end
    end

    function automatic in_t idle();
        in_t t = '0;
        t.rst_b = 1'b1;
        return t;
    endfunction

    // Apply one cycle of stimulus and queue its hand-computed outputs.
    task automatic cyc(input string nm, input in_t vi, input logic st, input logic bu,
                       input logic fl, input logic fi, input logic [1:0] xa, input logic [1:0] xb);
        exp_t e;
        v = vi;
        e.nm = nm; e.stall = st; e.bubble = bu; e.flush = fl; e.fire = fi;
        e.fa = xa; e.fb = xb; e.scnt = m_scnt; e.fcnt = m_fcnt; e.sat = m_sat;
        q.push_back(e);
        if (!vi.rst_b) begin
            m_scnt = 0; m_fcnt = 0; m_sat = 0;
        end else begin
            if (st) begin
                m_scnt = m_scnt + 1;
                if (m_sat != 3'd7) m_sat = m_sat + 3'd1;
            end
            if (fl) m_fcnt = m_fcnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_t t;
        int wait_cnt;
        v = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", '0, 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("idle", idle(), 0, 0, 0, 0, 2'b00, 2'b00);

        t = idle(); t.ex_memRead = 1; t.ex_dest = 8; t.id_uses_rs = 1; t.id_rs = 8;
        cyc("lu_rs", t, 1, 1, 0, 0, 2'b00, 2'b00);
        t = idle(); t.id_uses_rs = 1; t.id_rs = 8; t.mem_regWrite = 1; t.mem_dest = 8;
        cyc("lu_next", t, 0, 0, 0, 0, 2'b00, 2'b00);
        t = idle(); t.ex_rs = 8; t.wb_regWrite = 1; t.wb_dest = 8;
        cyc("lu_fwd", t, 0, 0, 0, 0, 2'b01, 2'b00);
        t = idle(); t.ex_memRead = 1; t.ex_dest = 9; t.id_uses_rt = 1; t.id_rt = 9;
        cyc("lu_rt", t, 1, 1, 0, 0, 2'b00, 2'b00);
        t = idle(); t.ex_memRead = 1; t.ex_dest = 0; t.id_uses_rs = 1; t.id_rs = 0;
        cyc("lu_zero", t, 0, 0, 0, 0, 2'b00, 2'b00);
        t = idle(); t.ex_memRead = 1; t.ex_dest = 8; t.id_rs = 8;
        cyc("lu_nouse", t, 0, 0, 0, 0, 2'b00, 2'b00);
        t = idle(); t.ex_memRead = 1; t.ex_dest = 8; t.id_uses_rs = 1; t.id_rs = 8; t.ex_redirect = 1;
        cyc("redir_lu", t, 0, 1, 1, 0, 2'b00, 2'b00);
        cyc("post_redir", idle(), 0, 0, 0, 0, 2'b00, 2'b00);

        t = idle(); t.ex_rs = 5; t.ex_rt = 6; t.mem_regWrite = 1; t.mem_dest = 5; t.wb_regWrite = 1; t.wb_dest = 5;
        cyc("fwd_mem", t, 0, 0, 0, 0, 2'b10, 2'b00);
        t.mem_regWrite = 0;
        cyc("fwd_wb", t, 0, 0, 0, 0, 2'b01, 2'b00);
        t = idle(); t.mem_regWrite = 1; t.wb_regWrite = 1;
        cyc("fwd_zero", t, 0, 0, 0, 0, 2'b00, 2'b00);
        t = idle(); t.ex_rs = 3; t.ex_rt = 7; t.mem_regWrite = 1; t.mem_dest = 7; t.wb_regWrite = 1; t.wb_dest = 3;
        cyc("fwd_b", t, 0, 0, 0, 0, 2'b01, 2'b10);

        t = idle(); t.id_sys = 1;
        cyc("sys_run", t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("sys_d1",  t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("sys_d2",  t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("sys_d3",  t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("sys_fire", t, 0, 1, 0, 1, 2'b00, 2'b00);
        cyc("sys_after", idle(), 0, 0, 0, 0, 2'b00, 2'b00);

        cyc("rd_run", t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("rd_d1",  t, 1, 1, 0, 0, 2'b00, 2'b00);
        t.ex_redirect = 1;
        cyc("rd_d2",  t, 0, 1, 1, 0, 2'b00, 2'b00);
        cyc("rd_after1", idle(), 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("rd_after2", idle(), 0, 0, 0, 0, 2'b00, 2'b00);

        t = idle(); t.ex_memRead = 1; t.ex_dest = 4; t.id_uses_rs = 1; t.id_rs = 4;
        cyc("sat_1", t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("sat_2", t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("sat_3", t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("sat_hold", idle(), 0, 0, 0, 0, 2'b00, 2'b00);

        t = idle(); t.id_sys = 1;
        cyc("rs_run", t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("rs_d1",  t, 1, 1, 0, 0, 2'b00, 2'b00);
        t.rst_b = 0;
        cyc("rs_rst", t, 1, 1, 0, 0, 2'b00, 2'b00);
        cyc("rs_after1", idle(), 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("rs_after2", idle(), 0, 0, 0, 0, 2'b00, 2'b00);
        cyc("rs_after3", idle(), 0, 0, 0, 0, 2'b00, 2'b00);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_queue left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
